// File: rtl/step_relay_pkg.sv
// Shared encodings for the step_relay node: FSM states, bus instruction
// codes and arithmetic operation selects.
package step_relay_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_HOLD    = 2'b01,
        ST_SEND    = 2'b10,
        ST_RELEASE = 2'b11
    } state_e;

    localparam logic [1:0] INSTR_IDLE  = 2'b00;
    localparam logic [1:0] INSTR_WRITE = 2'b10;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;

endpackage

// File: rtl/bin27.sv
// Hex nibble to seven-segment decoder; active-high segments, bit 0 = a .. bit 6 = g.
module bin27 (
    input  logic [3:0] bin,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h00;
        case (bin)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            4'hF:    seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/relay_fifo.sv
// Receive queue for step_relay: synchronous FIFO with registered full/empty
// flags; pushes while full and pops while empty are ignored.
module relay_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              push_ok_s;
    logic              pop_ok_s;

    always_comb begin
        push_ok_s = push & ~full_q;
        pop_ok_s  = pop & ~empty_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_ok_s && !pop_ok_s) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok_s && !push_ok_s) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end
        full_d  = (count_d == CNT_W'(FIFO_DEPTH));
        empty_d = (count_d == CNT_W'(0));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;

endmodule

// File: rtl/step_relay.sv
// Bus relay node: queues slave words, displays and holds each, applies an
// add/subtract/pass step and returns the result through the master port.
module step_relay
    import step_relay_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int DELAY_COUNT = 20,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [7*(DATA_W/4)-1:0]   seg,
    input  logic                      button,
    input  logic                      mode_en,
    input  logic [1:0]                op_sel,
    input  logic [3:0]                step,
    input  logic [DATA_W-1:0]         sw_data,
    input  logic                      m_tx_done,
    output logic [DATA_W-1:0]         m_data_out,
    output logic [1:0]                m_instruction,
    input  logic [DATA_W-1:0]         s_data,
    input  logic                      s_write_en_in,
    output logic                      fifo_full,
    output logic [7:0]                drop_count
);

    localparam int NDIG  = DATA_W / 4;
    localparam int CNT_W = $clog2(DELAY_COUNT + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] disp_q, disp_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        instr_q, instr_d;
    logic [7:0]        drop_q, drop_d;
    logic [DATA_W-1:0] result_s;
    logic [DATA_W-1:0] fifo_head_s;
    logic              fifo_push_s;
    logic              fifo_pop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;

    assign fifo_push_s = s_write_en_in & mode_en;

    relay_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push_s),
        .push_data (s_data),
        .pop       (fifo_pop_s),
        .pop_data  (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Full is judged before any same-cycle pop, so such a write still drops.
    always_comb begin
        drop_d = drop_q;
        if (fifo_push_s && fifo_full_s && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end else begin
            drop_d = drop_q;
        end
    end

    always_comb begin
        result_s = disp_q;
        case (op_sel)
            OP_ADD:  result_s = disp_q + DATA_W'(step);
            OP_SUB:  result_s = disp_q - DATA_W'(step);
            default: result_s = disp_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        disp_d     = disp_q;
        data_d     = data_q;
        instr_d    = instr_q;
        fifo_pop_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!fifo_empty_s) begin
                    fifo_pop_s = 1'b1;
                    disp_d     = fifo_head_s;
                    state_d    = ST_HOLD;
                end else if (button && mode_en) begin
                    disp_d  = sw_data;
                    data_d  = sw_data;
                    instr_d = INSTR_WRITE;
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_W'(DELAY_COUNT - 1)) begin
                    cnt_d   = '0;
                    disp_d  = result_s;
                    data_d  = result_s;
                    instr_d = INSTR_WRITE;
                    state_d = ST_SEND;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SEND: begin
                if (m_tx_done) begin
                    instr_d = INSTR_IDLE;
                    state_d = ST_RELEASE;
                end else begin
                    instr_d = INSTR_WRITE;
                end
            end
            ST_RELEASE: begin
                instr_d = INSTR_IDLE;
                state_d = ST_IDLE;
            end
            default: begin
                instr_d = INSTR_IDLE;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            disp_q  <= '0;
            data_q  <= '0;
            instr_q <= INSTR_IDLE;
            drop_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            data_q  <= data_d;
            instr_q <= instr_d;
            drop_q  <= drop_d;
        end
    end

    for (genvar k = 0; k < NDIG; k++) begin : g_digit
        bin27 u_bin27 (
            .bin (disp_q[4*k +: 4]),
            .seg (seg[7*k +: 7])
        );
    end

    assign m_data_out    = data_q;
    assign m_instruction = instr_q;
    assign fifo_full     = fifo_full_s;
    assign drop_count    = drop_q;

endmodule

// File: tb/tb_step_relay.sv
// Scoreboard bench for step_relay: stimulus queues expected master words,
// a monitor branch compares them as each send begins.
module tb_step_relay;

    localparam int DATA_W      = 8;
    localparam int DELAY_COUNT = 4;
    localparam int FIFO_DEPTH  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] seg;
    logic        button = 1'b0;
    logic        mode_en = 1'b1;
    logic [1:0]  op_sel = 2'b00;
    logic [3:0]  step = 4'd0;
    logic [7:0]  sw_data = 8'h00;
    logic        m_tx_done = 1'b0;
    logic [7:0]  m_data_out;
    logic [1:0]  m_instruction;
    logic [7:0]  s_data = 8'h00;
    logic        s_write_en_in = 1'b0;
    logic        fifo_full;
    logic [7:0]  drop_count;

    logic [7:0]  exp_q [$];
    int          n_checks = 0;
    int          n_fails = 0;

    step_relay #(
        .DATA_W      (DATA_W),
        .DELAY_COUNT (DELAY_COUNT),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .seg           (seg),
        .button        (button),
        .mode_en       (mode_en),
        .op_sel        (op_sel),
        .step          (step),
        .sw_data       (sw_data),
        .m_tx_done     (m_tx_done),
        .m_data_out    (m_data_out),
        .m_instruction (m_instruction),
        .s_data        (s_data),
        .s_write_en_in (s_write_en_in),
        .fifo_full     (fifo_full),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_write(input string name);
        int n;
        n = 0;
        while (m_instruction != 2'b10 && n < 40) begin
            tick();
            n++;
        end
        check(name, {30'd0, m_instruction}, 32'h2);
    endtask

    task automatic finish_tx();
        m_tx_done = 1'b1;
        tick();
        m_tx_done = 1'b0;
        check("instr_after_done", {30'd0, m_instruction}, 32'h0);
        tick();
        check("release_gap", {30'd0, m_instruction}, 32'h0);
    endtask

    task automatic run_word(input logic [7:0] d, input logic [1:0] op,
                            input logic [3:0] st, input logic [7:0] exp);
        op_sel = op;
        step = st;
        s_data = d;
        s_write_en_in = 1'b1;
        exp_q.push_back(exp);
        tick();
        s_write_en_in = 1'b0;
        wait_write("run_word_send");
        finish_tx();
    endtask

    initial begin
        fork
            begin : stimulus
                bit saw_write;
                #3;
                check("rst_instr", {30'd0, m_instruction}, 32'h0);
                check("rst_data", {24'd0, m_data_out}, 32'h0);
                check("rst_full", {31'd0, fifo_full}, 32'h0);
                check("rst_drop", {24'd0, drop_count}, 32'h0);
                check("rst_seg", {18'd0, seg}, {18'd0, 7'h3F, 7'h3F});
                tick();
                reset = 1'b0;
                tick();

                // Basic add of 3 to 0x41 with full timing checks
                op_sel = 2'b00;
                step = 4'd3;
                s_data = 8'h41;
                s_write_en_in = 1'b1;
                exp_q.push_back(8'h44);
                tick();
                s_write_en_in = 1'b0;
                tick();
                check("seg_after_pop", {18'd0, seg}, {18'd0, 7'h66, 7'h06});
                for (int i = 0; i < DELAY_COUNT - 1; i++) begin
                    tick();
                    check("instr_during_hold", {30'd0, m_instruction}, 32'h0);
                end
                tick();
                check("instr_after_hold", {30'd0, m_instruction}, 32'h2);
                check("seg_result", {18'd0, seg}, {18'd0, 7'h66, 7'h66});
                for (int i = 0; i < 3; i++) begin
                    tick();
                    check("send_held", {22'd0, m_instruction, m_data_out}, {22'd0, 2'b10, 8'h44});
                end
                finish_tx();

                run_word(8'hFE, 2'b00, 4'd3, 8'h01);
                run_word(8'h02, 2'b01, 4'd3, 8'hFF);
                run_word(8'h7C, 2'b10, 4'd3, 8'h7C);

                // Button injection; a second pulse during SEND is ignored
                sw_data = 8'h5A;
                button = 1'b1;
                exp_q.push_back(8'h5A);
                tick();
                button = 1'b0;
                check("button_instr", {30'd0, m_instruction}, 32'h2);
                check("button_data", {24'd0, m_data_out}, 32'h5A);
                sw_data = 8'h33;
                button = 1'b1;
                tick();
                button = 1'b0;
                check("button_in_send", {24'd0, m_data_out}, 32'h5A);
                finish_tx();
                saw_write = 1'b0;
                for (int i = 0; i < 6; i++) begin
                    tick();
                    if (m_instruction == 2'b10) saw_write = 1'b1;
                end
                check("no_second_button_send", {31'd0, saw_write}, 32'h0);

                // Burst of six writes with the master stalled
                op_sel = 2'b00;
                step = 4'd1;
                for (int i = 0; i < 6; i++) begin
                    s_data = 8'h10 + 8'(i);
                    s_write_en_in = 1'b1;
                    if (i < 5) exp_q.push_back(8'h11 + 8'(i));
                    tick();
                end
                s_write_en_in = 1'b0;
                check("burst_full", {31'd0, fifo_full}, 32'h1);
                check("burst_drop", {24'd0, drop_count}, 32'h1);
                for (int i = 0; i < 5; i++) begin
                    wait_write("burst_send");
                    finish_tx();
                end
                check("burst_drained_full", {31'd0, fifo_full}, 32'h0);

                // Reset asserted in HOLD with words still queued
                s_data = 8'h20;
                s_write_en_in = 1'b1;
                tick();
                s_data = 8'h21;
                tick();
                s_write_en_in = 1'b0;
                tick();
                #2;
                reset = 1'b1;
                #1;
                check("hold_rst_instr", {30'd0, m_instruction}, 32'h0);
                check("hold_rst_data", {24'd0, m_data_out}, 32'h0);
                check("hold_rst_drop", {24'd0, drop_count}, 32'h0);
                check("hold_rst_seg", {18'd0, seg}, {18'd0, 7'h3F, 7'h3F});
                @(negedge clk);
                reset = 1'b0;
                saw_write = 1'b0;
                for (int i = 0; i < DELAY_COUNT + 4; i++) begin
                    tick();
                    if (m_instruction == 2'b10) saw_write = 1'b1;
                end
                check("queue_emptied", {31'd0, saw_write}, 32'h0);
                run_word(8'h10, 2'b00, 4'd1, 8'h11);

                // Node disabled: write and button ignored
                mode_en = 1'b0;
                s_data = 8'h55;
                s_write_en_in = 1'b1;
                sw_data = 8'h66;
                button = 1'b1;
                tick();
                s_write_en_in = 1'b0;
                button = 1'b0;
                saw_write = 1'b0;
                for (int i = 0; i < DELAY_COUNT + 4; i++) begin
                    tick();
                    if (m_instruction != 2'b00) saw_write = 1'b1;
                end
                mode_en = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    tick();
                    if (m_instruction != 2'b00) saw_write = 1'b1;
                end
                check("disabled_instr", {31'd0, saw_write}, 32'h0);
                check("disabled_drop", {24'd0, drop_count}, 32'h0);
                check("disabled_full", {31'd0, fifo_full}, 32'h0);
                run_word(8'hA0, 2'b01, 4'd1, 8'h9F);

                tick();
                check("scoreboard_empty", exp_q.size(), 32'd0);
            end
            begin : monitor
                logic       prev_w;
                logic [7:0] e;
                prev_w = 1'b0;
                forever begin
                    @(negedge clk);
                    if (m_instruction == 2'b10 && !prev_w) begin
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_fails++;
                            $display("FAIL unexpected_send: got %0h expected no send", m_data_out);
                        end else begin
                            e = exp_q.pop_front();
                            check("send_data", {24'd0, m_data_out}, {24'd0, e});
                        end
                    end
                    prev_w = (m_instruction == 2'b10);
                end
            end
        join_any
        disable fork;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
